// File: rtl/alu_pkg.sv
// ALU control-code definitions, flag bit positions and code classification helpers.
package alu_pkg;

    localparam logic [3:0] ALUCON_AND = 4'b0000;
    localparam logic [3:0] ALUCON_OR  = 4'b0001;
    localparam logic [3:0] ALUCON_ADD = 4'b0010;
    localparam logic [3:0] ALUCON_SUB = 4'b0011;
    localparam logic [3:0] ALUCON_NOR = 4'b0100;
    localparam logic [3:0] ALUCON_XOR = 4'b0101;
    localparam logic [3:0] ALUCON_INC = 4'b0110;
    localparam logic [3:0] ALUCON_DEC = 4'b0111;
    localparam logic [3:0] ALUCON_NOT = 4'b1000;

    // Flag vector layout is {V,N,Z,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Codes above NOT are unassigned
    function automatic logic alucon_illegal(input logic [3:0] code);
        return code > ALUCON_NOT;
    endfunction

    // AVR-style status update: only add/sub are allowed to change the stored carry
    function automatic logic alucon_keeps_c(input logic [3:0] code);
        return !((code == ALUCON_ADD) || (code == ALUCON_SUB));
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {V,N,Z,C} for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       alu_con,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    logic [WIDTH-1:0] rhs;
    logic             sub_mode;
    logic             arith;
    logic [WIDTH:0]   sum;

    // Select the adder's second operand and direction; inc/dec reuse add/sub with a constant 1
    always_comb begin
        rhs      = op_b;
        sub_mode = 1'b0;
        arith    = 1'b0;
        case (alu_con)
            ALUCON_ADD: arith = 1'b1;
            ALUCON_SUB: begin arith = 1'b1; sub_mode = 1'b1; end
            ALUCON_INC: begin arith = 1'b1; rhs = WIDTH'(1); end
            ALUCON_DEC: begin arith = 1'b1; sub_mode = 1'b1; rhs = WIDTH'(1); end
            default:    ;
        endcase
        // Extra MSB is carry-out for add and borrow (A<B unsigned) for subtract
        sum = sub_mode ? ({1'b0, op_a} - {1'b0, rhs}) : ({1'b0, op_a} + {1'b0, rhs});
    end

    // Result mux and flag generation; illegal codes force everything to zero
    always_comb begin
        result  = '0;
        flags   = '0;
        illegal = 1'b0;
        case (alu_con)
            ALUCON_AND: result = op_a & op_b;
            ALUCON_OR:  result = op_a | op_b;
            ALUCON_NOR: result = ~(op_a | op_b);
            ALUCON_XOR: result = op_a ^ op_b;
            ALUCON_NOT: result = ~op_a;
            default:    result = sum[WIDTH-1:0];
        endcase
        if (arith) begin
            flags[FLAG_C] = sum[WIDTH];
            flags[FLAG_V] = sub_mode
                ? ((op_a[WIDTH-1] != rhs[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]))
                : ((op_a[WIDTH-1] == rhs[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]));
        end
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        if (alucon_illegal(alu_con)) begin
            result  = '0;
            flags   = '0;
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU plus EX/MEM result register with valid/ready handshake and flush.
// Optional persistent status register enabled by defining ALU_STATUS_REG_EN.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_con,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic [3:0]       sreg
);

    logic [WIDTH-1:0] c_result;
    logic [3:0]       c_flags;
    logic             c_illegal;
    logic             accept;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_con (alu_con),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (c_result),
        .flags   (c_flags),
        .illegal (c_illegal)
    );

    // Ready depends only on register state and downstream ready, never on in_valid
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // EX/MEM register: flush kills, accept loads, drained slot empties, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= c_result;
            flags     <= c_flags;
            illegal   <= c_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_STATUS_REG_EN
    logic [3:0] sreg_q;

    // Status register follows accepted legal ops; inc/dec/logic keep the previous carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else if (accept && !c_illegal) begin
            sreg_q <= alucon_keeps_c(alu_con) ? {c_flags[3:1], sreg_q[FLAG_C]} : c_flags;
        end
    end

    assign sreg = sreg_q;
`else
    assign sreg = 4'b0000;
`endif

endmodule
